maindec_mc: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/maindec_mc_outdec.sv | 110 +++++++++++
 rtl/maindec_mc.sv | 110 +++++++++++
 tb/tb_maindec_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, multicycle state codes and
// datapath control encodings used by the main and ALU decoders.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Code 14 is deliberately unused; the state register recovers from it.
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StImmWb   = 4'd10,
        StJEx     = 4'd11,
        StOriEx   = 4'd12,
        StBneEx   = 4'd13,
        StHalt    = 4'd15
    } state_e;

    // AluOr is the encoding the ALU decoder maps straight to OR.
    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluFunct = 2'b10,
        AluOr    = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SrcbRegB  = 2'b00,
        SrcbFour  = 2'b01,
        SrcbImm   = 2'b10,
        SrcbImmSh = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        PcAluResult = 2'b00,
        PcAluOut    = 2'b01,
        PcJump      = 2'b10
    } pcsrc_e;

endpackage

// File: rtl/maindec_mc_outdec.sv
// Combinational state-to-control decode for the multicycle main decoder.
module maindec_mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       rdy_i,
    output logic       pcwrite_o,
    output logic       irwrite_o,
    output logic       regwrite_o,
    output logic       memwrite_o,
    output logic       branch_o,
    output logic       branch_ne_o,
    output logic       iord_o,
    output logic       alusrca_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic       ext_zero_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [1:0] aluop_o,
    output logic       illegal_o
);

    // Decode controls from the current state; anything not set stays 0.
    always_comb begin
        pcwrite_o   = 1'b0;
        irwrite_o   = 1'b0;
        regwrite_o  = 1'b0;
        memwrite_o  = 1'b0;
        branch_o    = 1'b0;
        branch_ne_o = 1'b0;
        iord_o      = 1'b0;
        alusrca_o   = 1'b0;
        memtoreg_o  = 1'b0;
        regdst_o    = 1'b0;
        ext_zero_o  = 1'b0;
        alusrcb_o   = SrcbRegB;
        pcsrc_o     = PcAluResult;
        aluop_o     = AluAdd;
        illegal_o   = 1'b0;
        case (state_i)
            StFetch: begin
                alusrcb_o = SrcbFour;
                // PC+4 and IR load only once the fetch read has completed.
                irwrite_o = rdy_i;
                pcwrite_o = rdy_i;
            end
            StDecode: begin
                alusrcb_o = SrcbImmSh;
            end
            StMemAdr: begin
                alusrca_o = 1'b1;
                alusrcb_o = SrcbImm;
            end
            StMemRd: begin
                iord_o = 1'b1;
            end
            StMemWb: begin
                memtoreg_o = 1'b1;
                regwrite_o = 1'b1;
            end
            StMemWr: begin
                iord_o     = 1'b1;
                memwrite_o = 1'b1;
            end
            StRtypeEx: begin
                alusrca_o = 1'b1;
                aluop_o   = AluFunct;
            end
            StRtypeWb: begin
                regdst_o   = 1'b1;
                regwrite_o = 1'b1;
            end
            StBeqEx: begin
                alusrca_o = 1'b1;
                aluop_o   = AluSub;
                pcsrc_o   = PcAluOut;
                branch_o  = 1'b1;
            end
            StBneEx: begin
                alusrca_o   = 1'b1;
                aluop_o     = AluSub;
                pcsrc_o     = PcAluOut;
                branch_ne_o = 1'b1;
            end
            StAddiEx: begin
                alusrca_o = 1'b1;
                alusrcb_o = SrcbImm;
            end
            StOriEx: begin
                alusrca_o  = 1'b1;
                alusrcb_o  = SrcbImm;
                aluop_o    = AluOr;
                ext_zero_o = 1'b1;
            end
            StImmWb: begin
                regwrite_o = 1'b1;
            end
            StJEx: begin
                pcsrc_o   = PcJump;
                pcwrite_o = 1'b1;
            end
            StHalt: begin
                illegal_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/maindec_mc.sv
// Multicycle MIPS main control unit: state register, next-state logic,
// and reset gating of the write enables produced by the output decoder.
module maindec_mc
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned ILLEGAL_TRAP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       iord,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       regdst,
    output logic       ext_zero,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   rdy;
    logic   pcwrite_dec, irwrite_dec, regwrite_dec, memwrite_dec;

    assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Next-state selection; op only matters in DECODE and MEMADR.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:   state_d = rdy ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StRtypeEx;
                    OP_BEQ:       state_d = StBeqEx;
                    OP_BNE:       state_d = StBneEx;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_ORI:       state_d = StOriEx;
                    OP_J:         state_d = StJEx;
                    default:      state_d = (ILLEGAL_TRAP != 0) ? StHalt : StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   state_d = rdy ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = rdy ? StFetch : StMemWr;
            StRtypeEx: state_d = StRtypeWb;
            StRtypeWb: state_d = StFetch;
            StBeqEx:   state_d = StFetch;
            StBneEx:   state_d = StFetch;
            StAddiEx:  state_d = StImmWb;
            StOriEx:   state_d = StImmWb;
            StImmWb:   state_d = StFetch;
            StJEx:     state_d = StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StFetch;
        endcase
    end

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    maindec_mc_outdec u_outdec (
        .state_i     (state_q),
        .rdy_i       (rdy),
        .pcwrite_o   (pcwrite_dec),
        .irwrite_o   (irwrite_dec),
        .regwrite_o  (regwrite_dec),
        .memwrite_o  (memwrite_dec),
        .branch_o    (branch),
        .branch_ne_o (branch_ne),
        .iord_o      (iord),
        .alusrca_o   (alusrca),
        .memtoreg_o  (memtoreg),
        .regdst_o    (regdst),
        .ext_zero_o  (ext_zero),
        .alusrcb_o   (alusrcb),
        .pcsrc_o     (pcsrc),
        .aluop_o     (aluop),
        .illegal_o   (illegal)
    );

    // Reset kills writes in the same cycle it rises, e.g. mid MEMWR wait.
    always_comb begin
        pcwrite  = pcwrite_dec & ~reset;
        irwrite  = irwrite_dec & ~reset;
        regwrite = regwrite_dec & ~reset;
        memwrite = memwrite_dec & ~reset;
    end

    assign state = state_q;

endmodule

// File: tb/tb_maindec_mc.sv
// Bench for maindec_mc: three instances (default, no trap, no handshake),
// per-cycle vectors with expected state, reference control table per state.
module tb_maindec_mc;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       alusrca;
        logic       memtoreg;
        logic       regdst;
        logic       ext_zero;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        int         sel;
        logic [3:0] st;
    } vec_t;

    typedef struct {
        int   idx;
        int   sel;
        ctl_t exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    ctl_t       act [3];
    sb_t        sbq[$];
    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;
    int         vec_idx = 0;

    always #5 clk = ~clk;

    // 0: default, 1: ILLEGAL_TRAP=0, 2: MEM_HANDSHAKE=0 with mem_ready tied low
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Hs   = (g == 2) ? 0 : 1;
        localparam int unsigned Trap = (g == 1) ? 0 : 1;
        ctl_t a;
        logic mr;
        assign mr = (g == 2) ? 1'b0 : mem_ready;
        maindec_mc #(
            .MEM_HANDSHAKE (Hs),
            .ILLEGAL_TRAP  (Trap)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .op        (op),
            .mem_ready (mr),
            .pcwrite   (a.pcwrite),
            .irwrite   (a.irwrite),
            .regwrite  (a.regwrite),
            .memwrite  (a.memwrite),
            .branch    (a.branch),
            .branch_ne (a.branch_ne),
            .iord      (a.iord),
            .alusrca   (a.alusrca),
            .memtoreg  (a.memtoreg),
            .regdst    (a.regdst),
            .ext_zero  (a.ext_zero),
            .alusrcb   (a.alusrcb),
            .pcsrc     (a.pcsrc),
            .aluop     (a.aluop),
            .illegal   (a.illegal),
            .state     (a.state)
        );
        assign act[g] = a;
    end

    // Expected controls for a state, written out from the state table.
    function automatic ctl_t ref_out(input logic [3:0] st, input logic rdy, input logic rst);
        ctl_t c;
        c = '0;
        c.state = st;
        case (st)
            4'd0:  begin c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            4'd1:  c.alusrcb = 2'b11;
            4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd3:  c.iord = 1'b1;
            4'd4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            4'd6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            4'd7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            4'd8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            4'd13: begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch_ne = 1'b1; end
            4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd12: begin
                c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; c.ext_zero = 1'b1;
            end
            4'd10: c.regwrite = 1'b1;
            4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            4'd15: c.illegal = 1'b1;
            default: ;
        endcase
        if (rst) begin
            c.pcwrite  = 1'b0;
            c.irwrite  = 1'b0;
            c.regwrite = 1'b0;
            c.memwrite = 1'b0;
        end
        return c;
    endfunction

    task automatic add(input logic rst, input logic [5:0] o, input logic rdy, input int sel,
                       input logic [3:0] st);
        vec_t v;
        v.rst = rst; v.op = o; v.rdy = rdy; v.sel = sel; v.st = st;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic apply(input vec_t v);
        sb_t s;
        logic eff_rdy;
        @(posedge clk);
        #1;
        reset     = v.rst;
        op        = v.op;
        mem_ready = v.rdy;
        eff_rdy   = (v.sel == 2) ? 1'b1 : v.rdy;
        s.idx = vec_idx;
        s.sel = v.sel;
        s.exp = ref_out(v.st, eff_rdy, v.rst);
        sbq.push_back(s);
        vec_idx++;
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Compare away from the active edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            sb_t s;
            ctl_t a;
            s = sbq.pop_front();
            a = act[s.sel];
            checks++;
            if (a.state !== s.exp.state) begin
                errors++;
                $display("FAIL vec%0d dut%0d state: got %0d want %0d",
                         s.idx, s.sel, a.state, s.exp.state);
            end
            checks++;
            if (a !== s.exp) begin
                errors++;
                $display("FAIL vec%0d dut%0d controls: got %h want %h",
                         s.idx, s.sel, a, s.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 2 cycles, then R-type
        add(1, OP_RTYPE, 1, 0, 0);
        add(1, OP_RTYPE, 1, 0, 0);
        add(0, OP_RTYPE, 1, 0, 0);
        add(0, OP_RTYPE, 1, 0, 1);
        add(0, OP_RTYPE, 1, 0, 6);
        add(0, OP_RTYPE, 1, 0, 7);
        // LW with three wait cycles in MEMRD
        add(0, OP_LW, 1, 0, 0);
        add(0, OP_LW, 1, 0, 1);
        add(0, OP_LW, 1, 0, 2);
        add(0, OP_LW, 0, 0, 3);
        add(0, OP_LW, 0, 0, 3);
        add(0, OP_LW, 0, 0, 3);
        add(0, OP_LW, 1, 0, 3);
        add(0, OP_LW, 1, 0, 4);
        // BNE then ORI
        add(0, OP_BNE, 1, 0, 0);
        add(0, OP_BNE, 1, 0, 1);
        add(0, OP_BNE, 1, 0, 13);
        add(0, OP_ORI, 1, 0, 0);
        add(0, OP_ORI, 1, 0, 1);
        add(0, OP_ORI, 1, 0, 12);
        add(0, OP_ORI, 1, 0, 10);
        // FETCH stall, then SW with reset on the 2nd wait cycle
        add(0, OP_SW, 0, 0, 0);
        add(0, OP_SW, 1, 0, 0);
        add(0, OP_SW, 1, 0, 1);
        add(0, OP_SW, 1, 0, 2);
        add(0, OP_SW, 0, 0, 5);
        add(1, OP_SW, 0, 0, 5);
        // ADDI with op changing outside DECODE/MEMADR
        add(0, OP_ADDI, 1, 0, 0);
        add(0, OP_ADDI, 1, 0, 1);
        add(0, OP_J, 1, 0, 9);
        add(0, OP_BEQ, 1, 0, 10);
        // BEQ with mem_ready low in a non-memory state
        add(0, OP_BEQ, 1, 0, 0);
        add(0, OP_BEQ, 1, 0, 1);
        add(0, OP_BEQ, 0, 0, 8);
        // Illegal opcode: sticky HALT until reset
        add(0, 6'h3f, 1, 0, 0);
        add(0, 6'h3f, 1, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 6'h3f, 1'(i % 2), 0, 15);
        add(1, OP_RTYPE, 1, 0, 15);
        add(0, OP_RTYPE, 0, 0, 0);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        foreach (vecs[i]) apply(vecs[i]);

        // ILLEGAL_TRAP=0: unknown opcode runs as NOP
        vecs.delete();
        add(0, 6'h3f, 1, 1, 0);
        add(0, 6'h3f, 1, 1, 1);
        add(0, 6'h3f, 1, 1, 0);
        reset_cycle();
        foreach (vecs[i]) apply(vecs[i]);

        // MEM_HANDSHAKE=0 with mem_ready tied low: J then SW never wait
        vecs.delete();
        add(0, OP_J, 0, 2, 0);
        add(0, OP_J, 0, 2, 1);
        add(0, OP_J, 0, 2, 11);
        add(0, OP_SW, 0, 2, 0);
        add(0, OP_SW, 0, 2, 1);
        add(0, OP_SW, 0, 2, 2);
        add(0, OP_SW, 0, 2, 5);
        add(0, OP_SW, 0, 2, 0);
        reset_cycle();
        foreach (vecs[i]) apply(vecs[i]);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
